// File: rtl/t_trig_seq_ctrl.sv
// t_trig_seq_ctrl: sequencer for the toggle input of a downstream t_trig.
// An accepted start latches a period P and a pulse count N; the block then
// emits N single-cycle toggle-enable pulses, one every P clocks, and flags done.
// A shadow of the t_trig output (o_q_exp) is kept for checking.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        start request, sampled only in idle
//   i_stop         abort request, honoured while running (wins over start in idle)
//   i_period       toggle period P, latched on an accepted start
//   i_num_toggles  pulse count N, latched on an accepted start
//   o_t            registered toggle enable for t_trig
//   o_busy         high while running
//   o_done         one-cycle pulse after the Nth toggle
//   o_abort        one-cycle pulse when a run is stopped
//   o_err          one-cycle pulse when a start with P==0 or N==0 is rejected
//   o_toggle_cnt   toggles issued in the current or last run
//   o_q_exp        expected t_trig output, flips on every edge with o_t high
module t_trig_seq_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_num_toggles,
    output logic             o_t,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_abort,
    output logic             o_err,
    output logic [CNT_W-1:0] o_toggle_cnt,
    output logic             o_q_exp
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] down_q, down_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_q, t_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic             q_exp_q, q_exp_d;

    logic             start_req;
    logic             start_ok;
    logic             start_bad;
    logic             toggle_due;
    logic [CNT_W-1:0] cnt_inc;

    // Stop has priority over start in idle, so a start is only seen without stop.
    assign start_req  = (state_q == StIdle) && !i_stop && i_start;
    assign start_bad  = start_req && ((i_period == '0) || (i_num_toggles == '0));
    assign start_ok   = start_req && !start_bad;
    // A stop on the same edge as a due toggle suppresses the pulse.
    assign toggle_due = (state_q == StRun) && !i_stop && (down_q == '0);
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // State register and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            period_q <= '0;
            num_q    <= '0;
            down_q   <= '0;
            cnt_q    <= '0;
            t_q      <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
            q_exp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            num_q    <= num_d;
            down_q   <= down_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            q_exp_q  <= q_exp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) state_d = StRun;
            end
            StRun: begin
                if (i_stop) begin
                    state_d = StIdle;
                end else if (toggle_due && (cnt_inc == num_q)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        period_d = period_q;
        num_d    = num_q;
        down_d   = down_q;
        cnt_d    = cnt_q;
        t_d      = toggle_due;
        done_d   = (state_q == StDone);
        abort_d  = (state_q == StRun) && i_stop;
        err_d    = start_bad;
        // Never cleared by start/stop/done: models a t_trig without reset.
        q_exp_d  = q_exp_q ^ t_q;

        if (start_ok) begin
            period_d = i_period;
            num_d    = i_num_toggles;
            down_d   = i_period - CNT_W'(1);
            cnt_d    = '0;
        end else if ((state_q == StRun) && !i_stop) begin
            if (down_q == '0) begin
                down_d = period_q - CNT_W'(1);
                cnt_d  = cnt_inc;
            end else begin
                down_d = down_q - CNT_W'(1);
            end
        end
    end

    assign o_t          = t_q;
    assign o_busy       = (state_q == StRun);
    assign o_done       = done_q;
    assign o_abort      = abort_q;
    assign o_err        = err_q;
    assign o_toggle_cnt = cnt_q;
    assign o_q_exp      = q_exp_q;

endmodule

// File: tb/tb_t_trig_seq_ctrl.sv
// Directed self-checking bench for t_trig_seq_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge; per-edge output activity is
// gathered into bit vectors (bit i = value after the i-th rising edge of a
// capture window) and compared against hand-computed patterns.
module tb_t_trig_seq_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] num_toggles;
    logic             t;
    logic             busy;
    logic             done;
    logic             abort;
    logic             err;
    logic [CNT_W-1:0] toggle_cnt;
    logic             q_exp;

    int errors = 0;
    int checks = 0;

    logic [31:0] t_vec, done_vec, abort_vec, err_vec, busy_vec;

    t_trig_seq_ctrl #(
        .CNT_W(CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_period     (period),
        .i_num_toggles(num_toggles),
        .o_t          (t),
        .o_busy       (busy),
        .o_done       (done),
        .o_abort      (abort),
        .o_err        (err),
        .o_toggle_cnt (toggle_cnt),
        .o_q_exp      (q_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, recording outputs after each one.
    task automatic capture(input int n);
        t_vec = '0; done_vec = '0; abort_vec = '0; err_vec = '0; busy_vec = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            t_vec[i]     = t;
            done_vec[i]  = done;
            abort_vec[i] = abort;
            err_vec[i]   = err;
            busy_vec[i]  = busy;
        end
    endtask

    // Present a start for exactly one rising edge.
    task automatic do_start(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] n);
        start = 1'b1; period = p; num_toggles = n;
        @(negedge clk);
        start = 1'b0; period = 8'hAA; num_toggles = 8'h55;
    endtask

    function automatic logic [31:0] all_outs();
        return {19'd0, t, busy, done, abort, err, toggle_cnt, q_exp};
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; period = '0; num_toggles = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: P=3, N=4
        do_start(8'd3, 8'd4);
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        capture(14);
        check("t1_t_pattern", t_vec, 32'h0000_1248);
        check("t1_done_pattern", done_vec, 32'h0000_2000);
        check("t1_busy_pattern", busy_vec, 32'h0000_0FFE);
        check("t1_toggle_cnt", {24'd0, toggle_cnt}, 32'd4);
        check("t1_q_exp", {31'd0, q_exp}, 32'd0);

        // 2: P=1, N=5 -> back-to-back pulses
        do_start(8'd1, 8'd5);
        capture(8);
        check("t2_t_pattern", t_vec, 32'h0000_003E);
        check("t2_done_pattern", done_vec, 32'h0000_0040);
        check("t2_busy_pattern", busy_vec, 32'h0000_001E);
        check("t2_toggle_cnt", {24'd0, toggle_cnt}, 32'd5);
        check("t2_q_exp", {31'd0, q_exp}, 32'd1);

        // 3: P=4, N=10, stop after the 2nd pulse
        do_start(8'd4, 8'd10);
        capture(8);
        check("t3_t_before_stop", t_vec, 32'h0000_0110);
        stop = 1'b1;
        capture(1);
        stop = 1'b0;
        check("t3_abort_pulse", abort_vec, 32'h0000_0002);
        check("t3_t_at_stop", t_vec, 32'h0);
        check("t3_busy_at_stop", busy_vec, 32'h0);
        capture(12);
        check("t3_t_after", t_vec, 32'h0);
        check("t3_done_after", done_vec, 32'h0);
        check("t3_abort_once", abort_vec, 32'h0);
        check("t3_toggle_cnt", {24'd0, toggle_cnt}, 32'd2);
        check("t3_q_exp", {31'd0, q_exp}, 32'd1);

        // 4: rejected starts and stop-over-start
        do_start(8'd0, 8'd3);
        check("t4_err_p0", {29'd0, err, busy, t}, 32'b100);
        @(negedge clk);
        check("t4_err_one_cycle", {31'd0, err}, 32'd0);
        do_start(8'd3, 8'd0);
        check("t4_err_n0", {29'd0, err, busy, t}, 32'b100);
        stop = 1'b1;
        do_start(8'd2, 8'd2);
        stop = 1'b0;
        check("t4_stop_wins", {28'd0, err, busy, t, abort}, 32'h0);
        capture(6);
        check("t4_no_activity", t_vec | busy_vec | err_vec | done_vec | abort_vec, 32'h0);
        check("t4_toggle_cnt_held", {24'd0, toggle_cnt}, 32'd2);

        // 5: start during RUN and during DONE are ignored
        do_start(8'd3, 8'd2);
        start = 1'b1; period = 8'd2; num_toggles = 8'd2;
        capture(2);
        start = 1'b0;
        check("t5_busy_during_restart", busy_vec, 32'h0000_0006);
        check("t5_no_t_no_err", t_vec | err_vec, 32'h0);
        capture(4);
        check("t5_t_pattern", t_vec, 32'h0000_0012);
        start = 1'b1; period = 8'd2; num_toggles = 8'd2;
        capture(1);
        start = 1'b0;
        check("t5_done_with_start", {done_vec[1], err_vec[1], t_vec[1]}, 32'b100);
        capture(3);
        check("t5_idle_after", t_vec | busy_vec | err_vec, 32'h0);
        check("t5_toggle_cnt", {24'd0, toggle_cnt}, 32'd2);
        check("t5_q_exp", {31'd0, q_exp}, 32'd1);

        // 6: asynchronous reset mid-run, then a fresh run
        do_start(8'd2, 8'd5);
        capture(5);
        check("t6_t_before_reset", t_vec, 32'h0000_0014);
        check("t6_state_before_reset", {22'd0, busy, toggle_cnt, q_exp}, {22'd0, 1'b1, 8'd2, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", all_outs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        capture(3);
        check("t6_no_pulse_after_reset", done_vec | abort_vec | t_vec | busy_vec, 32'h0);
        do_start(8'd2, 8'd1);
        capture(4);
        check("t6_t_pattern", t_vec, 32'h0000_0004);
        check("t6_done_pattern", done_vec, 32'h0000_0008);
        check("t6_busy_pattern", busy_vec, 32'h0000_0002);
        check("t6_toggle_cnt", {24'd0, toggle_cnt}, 32'd1);
        check("t6_q_exp", {31'd0, q_exp}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
